// File: rtl/isdu_control.sv
// Control FSM for a small LC-3 style datapath: fetch/decode/execute sequencing,
// datapath load/gate/select strobes and a wait-stated SRAM handshake.
module isdu_control #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] opcode,
  input  logic       ir5,
  input  logic       ir11,
  input  logic       BEN,
  output logic       ld_mar,
  output logic       ld_mdr,
  output logic       ld_ir,
  output logic       ld_ben,
  output logic       ld_cc,
  output logic       ld_reg,
  output logic       ld_pc,
  output logic       ld_led,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] pcmux_sel,
  output logic       drmux_sel,
  output logic       sr1mux_sel,
  output logic       sr2mux_sel,
  output logic       addr1mux_sel,
  output logic [1:0] addr2mux_sel,
  output logic [1:0] aluk,
  output logic       mio_en,
  output logic       mem_ce_n,
  output logic       mem_oe_n,
  output logic       mem_we_n
);
  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CW-1:0] WMAX = CW'(MEM_WAIT);

  typedef enum logic [4:0] {
    HALTED, FETCH1, FETCH2, FETCH3, DECODE,
    EX_ADD, EX_AND, EX_NOT, EX_BR, EX_BR_TAKEN, EX_JMP, EX_JSR1, EX_JSR2,
    LDR1, LDR2, LDR3, STR1, STR2, STR3, PAUSE1, PAUSE2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          wdone;

  assign wdone = (wcnt_q == WMAX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HALTED:  if (Run) state_d = FETCH1;
      FETCH1:  state_d = FETCH2;
      FETCH2:  if (wdone) state_d = FETCH3;
      FETCH3:  state_d = DECODE;
      DECODE: begin
        case (opcode)
          4'b0001: state_d = EX_ADD;
          4'b0101: state_d = EX_AND;
          4'b1001: state_d = EX_NOT;
          4'b0000: state_d = EX_BR;
          4'b1100: state_d = EX_JMP;
          4'b0100: state_d = EX_JSR1;
          4'b0110: state_d = LDR1;
          4'b0111: state_d = STR1;
          4'b1101: state_d = PAUSE1;
          default: state_d = FETCH1;
        endcase
      end
      EX_ADD, EX_AND, EX_NOT, EX_BR_TAKEN, EX_JMP, EX_JSR2, LDR3:
               state_d = FETCH1;
      EX_BR:   state_d = BEN ? EX_BR_TAKEN : FETCH1;
      EX_JSR1: state_d = EX_JSR2;
      LDR1:    state_d = LDR2;
      LDR2:    if (wdone) state_d = LDR3;
      STR1:    state_d = STR2;
      STR2:    state_d = STR3;
      STR3:    if (wdone) state_d = FETCH1;
      PAUSE1:  if (Continue) state_d = PAUSE2;
      PAUSE2:  if (!Continue) state_d = FETCH1;
      default: state_d = HALTED;
    endcase
    // Counter restarts on every state change so each memory state sees 0 on entry.
    if (state_d != state_q) wcnt_d = '0;
    else                    wcnt_d = wdone ? wcnt_q : wcnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HALTED;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Outputs decode the live state so an async reset drops memory strobes at once.
  always_comb begin
    ld_mar = 1'b0; ld_mdr = 1'b0; ld_ir = 1'b0; ld_ben = 1'b0;
    ld_cc = 1'b0; ld_reg = 1'b0; ld_pc = 1'b0; ld_led = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    pcmux_sel = 2'b00; drmux_sel = 1'b0; sr1mux_sel = 1'b0; sr2mux_sel = 1'b0;
    addr1mux_sel = 1'b0; addr2mux_sel = 2'b00; aluk = 2'b00;
    mio_en = 1'b0; mem_ce_n = 1'b1; mem_oe_n = 1'b1; mem_we_n = 1'b1;
    unique case (state_q)
      FETCH1: begin GatePC = 1'b1; ld_mar = 1'b1; ld_pc = 1'b1; end
      FETCH2, LDR2: begin
        mem_ce_n = 1'b0; mem_oe_n = 1'b0; mio_en = 1'b1;
        ld_mdr = wdone;
      end
      FETCH3: begin GateMDR = 1'b1; ld_ir = 1'b1; end
      DECODE: ld_ben = 1'b1;
      EX_ADD, EX_AND, EX_NOT: begin
        GateALU = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1;
        drmux_sel = 1'b1; sr1mux_sel = 1'b1;
        sr2mux_sel = (state_q == EX_NOT) ? 1'b0 : ~ir5;
        aluk = (state_q == EX_ADD) ? 2'b00 : (state_q == EX_AND) ? 2'b01 : 2'b10;
      end
      EX_BR_TAKEN: begin
        ld_pc = 1'b1; pcmux_sel = 2'b10; addr1mux_sel = 1'b1; addr2mux_sel = 2'b01;
      end
      EX_JMP: begin
        ld_pc = 1'b1; pcmux_sel = 2'b01; GateALU = 1'b1; aluk = 2'b11; sr1mux_sel = 1'b1;
      end
      EX_JSR1: begin GatePC = 1'b1; ld_reg = 1'b1; drmux_sel = 1'b0; end
      EX_JSR2: begin
        ld_pc = 1'b1;
        if (ir11) begin
          pcmux_sel = 2'b10; addr1mux_sel = 1'b1; addr2mux_sel = 2'b00;
        end else begin
          pcmux_sel = 2'b01; GateALU = 1'b1; aluk = 2'b11; sr1mux_sel = 1'b1;
        end
      end
      LDR1, STR1: begin
        GateMARMUX = 1'b1; ld_mar = 1'b1; addr1mux_sel = 1'b0;
        addr2mux_sel = 2'b10; sr1mux_sel = 1'b1;
      end
      LDR3: begin GateMDR = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1; drmux_sel = 1'b1; end
      STR2: begin GateALU = 1'b1; aluk = 2'b11; sr1mux_sel = 1'b0; ld_mdr = 1'b1; end
      // Write strobe releases one cycle before chip enable to close the write cleanly.
      STR3: begin mem_ce_n = 1'b0; mem_oe_n = 1'b1; mem_we_n = wdone; end
      PAUSE1: ld_led = 1'b1;
      default: ;
    endcase
  end

endmodule
